// File: rtl/lsu_mem_controller.sv
// Load/store sequencer between the pipeline issue point and a single-port
// data memory with a variable-latency req/ack handshake.
module lsu_mem_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_BUS   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_funct3;
    logic [2:0]    w_funct3_nxt;
    logic [1:0]    r_off;
    logic [1:0]    w_off_nxt;

    logic          r_mem_req;
    logic          w_mem_req_nxt;
    logic          r_mem_we;
    logic          w_mem_we_nxt;
    logic [3:0]    r_mem_be;
    logic [3:0]    w_mem_be_nxt;
    logic [31:0]   r_mem_addr;
    logic [31:0]   w_mem_addr_nxt;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   w_mem_wdata_nxt;

    logic          r_resp_valid;
    logic          w_resp_valid_nxt;
    logic [31:0]   r_resp_data;
    logic [31:0]   w_resp_data_nxt;
    logic [4:0]    r_resp_rd;
    logic [4:0]    w_resp_rd_nxt;
    logic [1:0]    r_resp_err;
    logic [1:0]    w_resp_err_nxt;

    logic          w_legal;
    logic          w_misal;
    logic [3:0]    w_st_be;
    logic [31:0]   w_st_wdata;
    logic [31:0]   w_shifted;
    logic [31:0]   w_ld_data;

    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !req_is_store;
            default:                w_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes access size for both loads and stores
    assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << req_addr[1:0];
                w_st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << req_addr[1:0];
                w_st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = req_wdata;
            end
        endcase
    end

    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld_data = w_shifted;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
            3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_funct3_nxt     = r_funct3;
        w_off_nxt        = r_off;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_be_nxt     = r_mem_be;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_data_nxt  = r_resp_data;
        w_resp_rd_nxt    = r_resp_rd;
        w_resp_err_nxt   = r_resp_err;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_resp_rd_nxt = req_rd;
                    w_funct3_nxt  = req_funct3;
                    w_off_nxt     = req_addr[1:0];
                    if (!w_legal || w_misal) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_data_nxt  = 32'd0;
                        w_resp_err_nxt   = !w_legal ? ERR_F3 : ERR_ALIGN;
                        w_state_nxt      = S_RESP;
                    end else begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = req_is_store;
                        w_mem_be_nxt    = req_is_store ? w_st_be : 4'b1111;
                        w_mem_addr_nxt  = {req_addr[31:2], 2'b00};
                        w_mem_wdata_nxt = req_is_store ? w_st_wdata : 32'd0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    w_mem_req_nxt    = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_data_nxt  = r_mem_we ? 32'd0 : w_ld_data;
                    w_resp_err_nxt   = ERR_OK;
                    w_state_nxt      = S_RESP;
                end else if (r_cnt == LAST) begin
                    w_mem_req_nxt    = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_data_nxt  = 32'd0;
                    w_resp_err_nxt   = ERR_BUS;
                    w_state_nxt      = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_rd    <= 5'd0;
            r_resp_err   <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_funct3     <= w_funct3_nxt;
            r_off        <= w_off_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_be     <= w_mem_be_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_rd    <= w_resp_rd_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_resp_rd;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Directed bench for lsu_mem_controller: hand-computed loads, stores,
// faults, timeout, backpressure and async reset mid-access.
module tb_lsu_mem_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_controller #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic ack_after(input int waits, input logic [31:0] rdata);
        for (int i = 0; i < waits; i++) begin
            step();
            check("req_hold", {31'd0, mem_req}, 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        check("req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] d,
                               input logic [1:0] e, input logic [4:0] rd);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_data"}, resp_data, d);
        check({tag, "_err"}, {30'd0, resp_err}, {30'd0, e});
        check({tag, "_rd"}, {27'd0, resp_rd}, {27'd0, rd});
        check({tag, "_rdy0"}, {31'd0, req_ready}, 32'd0);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("resp_clr", {31'd0, resp_valid}, 32'd0);
        check("rdy_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mreq", {31'd0, mem_req}, 32'd0);
        check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_err", {30'd0, resp_err}, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;
        step();

        // LB at offset 3, two wait cycles
        issue(1'b0, 3'b000, 32'h0000_1003, 32'd0, 5'd7);
        check("lb_req", {31'd0, mem_req}, 32'd1);
        check("lb_addr", mem_addr, 32'h0000_1000);
        check("lb_be", {28'd0, mem_be}, 32'h0000_000F);
        check("lb_we", {31'd0, mem_we}, 32'd0);
        ack_after(2, 32'h80AA_55CC);
        expect_resp("lb", 32'hFFFF_FF80, 2'b00, 5'd7);
        finish_resp();

        issue(1'b0, 3'b101, 32'h0000_2002, 32'd0, 5'd3);
        ack_after(0, 32'hBEEF_1234);
        expect_resp("lhu", 32'h0000_BEEF, 2'b00, 5'd3);
        finish_resp();

        issue(1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd4);
        ack_after(1, 32'hBEEF_1234);
        expect_resp("lh", 32'hFFFF_BEEF, 2'b00, 5'd4);
        finish_resp();

        issue(1'b0, 3'b100, 32'h0000_2001, 32'd0, 5'd9);
        ack_after(0, 32'h1234_8A00);
        expect_resp("lbu", 32'h0000_008A, 2'b00, 5'd9);
        finish_resp();

        issue(1'b1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 5'd1);
        check("sb_we", {31'd0, mem_we}, 32'd1);
        check("sb_be", {28'd0, mem_be}, 32'h0000_0002);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_addr", mem_addr, 32'h0000_3000);
        ack_after(0, 32'hFFFF_FFFF);
        expect_resp("sb", 32'd0, 2'b00, 5'd1);
        finish_resp();

        issue(1'b1, 3'b001, 32'h0000_3002, 32'h1234_56A5, 5'd2);
        check("sh_we", {31'd0, mem_we}, 32'd1);
        check("sh_be", {28'd0, mem_be}, 32'h0000_000C);
        check("sh_wdata", mem_wdata, 32'h56A5_56A5);
        ack_after(3, 32'h0);
        expect_resp("sh", 32'd0, 2'b00, 5'd2);
        finish_resp();

        issue(1'b1, 3'b010, 32'h0000_3004, 32'hCAFE_F00D, 5'd6);
        check("sw_be", {28'd0, mem_be}, 32'h0000_000F);
        check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
        ack_after(0, 32'h0);
        expect_resp("sw", 32'd0, 2'b00, 5'd6);
        finish_resp();

        issue(1'b0, 3'b010, 32'h0000_4001, 32'd0, 5'd11);
        check("mis_mreq", {31'd0, mem_req}, 32'd0);
        expect_resp("mis", 32'd0, 2'b01, 5'd11);
        step();
        check("mis_mreq2", {31'd0, mem_req}, 32'd0);
        finish_resp();

        issue(1'b1, 3'b100, 32'h0000_4000, 32'd0, 5'd12);
        check("ilst_mreq", {31'd0, mem_req}, 32'd0);
        expect_resp("ilst", 32'd0, 2'b10, 5'd12);
        finish_resp();

        issue(1'b0, 3'b011, 32'h0000_4001, 32'd0, 5'd13);
        check("prio_mreq", {31'd0, mem_req}, 32'd0);
        expect_resp("prio", 32'd0, 2'b10, 5'd13);
        finish_resp();

        // Bus timeout: count cycles mem_req stays high
        issue(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd14);
        cnt = 0;
        while (mem_req && cnt < 40) begin
            cnt++;
            step();
        end
        check("to_cycles", cnt, 32'd16);
        expect_resp("to", 32'd0, 2'b11, 5'd14);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ack   = 1'b0;
        check("late_mreq", {31'd0, mem_req}, 32'd0);
        expect_resp("late", 32'd0, 2'b11, 5'd14);
        finish_resp();

        // Backpressure with a stray req_valid during RESP
        issue(1'b0, 3'b010, 32'h0000_0010, 32'd0, 5'd15);
        ack_after(0, 32'h1122_3344);
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0020;
        for (int i = 0; i < 5; i++) begin
            expect_resp("bp", 32'h1122_3344, 2'b00, 5'd15);
            check("bp_mreq", {31'd0, mem_req}, 32'd0);
            step();
        end
        req_valid = 1'b0;
        finish_resp();

        // Async reset while waiting for ack
        issue(1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd16);
        check("pre_rst_mreq", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mreq", {31'd0, mem_req}, 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        check("arst_rvalid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_rvalid", {31'd0, resp_valid}, 32'd0);
        issue(1'b0, 3'b010, 32'h0000_0000, 32'd0, 5'd17);
        check("post_addr", mem_addr, 32'h0000_0000);
        ack_after(1, 32'hDEAD_BEEF);
        expect_resp("post", 32'hDEAD_BEEF, 2'b00, 5'd17);
        finish_resp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
